washing_machine: RTL and testbench



---
 rtl/washing_machine_if.sv | 36 +++
 rtl/washing_machine.sv | 165 ++++++++++++++++
 tb/tb_washing_machine.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/washing_machine_if.sv
// Bundles the coin acceptor / front panel / sensor inputs and the actuator
// outputs of the washing-machine controller.
// master: the environment (panel, sensors, actuator drivers).
// slave: the controller.
interface washing_machine_if;
  logic [1:0] coin;
  logic       door_close;
  logic       start;
  logic       filled;
  logic       detergent_added;
  logic       cycle_timeout;
  logic       drained;
  logic       spin_timeout;
  logic       door_lock;
  logic       motor_on;
  logic       fill_value_on;
  logic       drain_value_on;
  logic       done;
  logic       soap_wash;
  logic       water_wash;
  logic [1:0] change;

  modport master (
    output coin, door_close, start, filled, detergent_added,
           cycle_timeout, drained, spin_timeout,
    input  door_lock, motor_on, fill_value_on, drain_value_on,
           done, soap_wash, water_wash, change
  );

  modport slave (
    input  coin, door_close, start, filled, detergent_added,
           cycle_timeout, drained, spin_timeout,
    output door_lock, motor_on, fill_value_on, drain_value_on,
           done, soap_wash, water_wash, change
  );
endinterface

// File: rtl/washing_machine.sv
// Coin-operated washing-machine controller.
// Price is 2 units; a 3-unit coin returns one unit of change as a one-cycle
// pulse during the first FILL cycle. Program: FILL, DETERGENT, CYCLE, DRAIN,
// SPIN, DONE, with all timing supplied by external sensors/timers.
// Optional feature macro: RINSE_PASS_EN -- adds one rinse pass
// (FILL, CYCLE, DRAIN without detergent) after the soap pass drain.
module washing_machine (
  input  logic                clk,
  input  logic                reset,
  washing_machine_if.slave    bus
);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    DETERGENT,
    CYCLE,
    DRAIN,
    SPIN,
    DONE
  } state_t;

  state_t     state;
  state_t     next_state;
  logic       soap_wash_q;
  logic       water_wash_q;
  logic [1:0] change_q;
  logic       soap_set;
  logic       water_set;
  logic       flags_clr;
  logic [1:0] change_next;

  // Next-state logic plus the one-shot controls for the flags and change pulse.
  always_comb begin
    next_state  = state;
    soap_set    = 1'b0;
    water_set   = 1'b0;
    flags_clr   = 1'b0;
    change_next = '0;
    case (state)
      IDLE: begin
        if (bus.start && bus.door_close && (bus.coin >= 2'd2)) begin
          next_state = FILL;
          if (bus.coin == 2'b11) begin
            change_next = 2'b01;
          end
        end
      end
      FILL: begin
        // The soap flag tells the first fill apart from the rinse fill.
        if (bus.filled) begin
          next_state = soap_wash_q ? CYCLE : DETERGENT;
        end
      end
      DETERGENT: begin
        if (bus.detergent_added) begin
          next_state = CYCLE;
          soap_set   = 1'b1;
        end
      end
      CYCLE: begin
        if (bus.cycle_timeout) begin
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.drained) begin
`ifdef RINSE_PASS_EN
          if (!water_wash_q) begin
            next_state = FILL;
            water_set  = 1'b1;
          end else begin
            next_state = SPIN;
          end
`else
          next_state = SPIN;
`endif
        end
      end
      SPIN: begin
        if (bus.spin_timeout) begin
          next_state = DONE;
        end
      end
      DONE: begin
        if (!bus.door_close) begin
          next_state = IDLE;
          flags_clr  = 1'b1;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State register, pass flags and change pulse; reset aborts any program.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      soap_wash_q  <= 1'b0;
      water_wash_q <= 1'b0;
      change_q     <= '0;
    end else begin
      state    <= next_state;
      change_q <= change_next;
      if (flags_clr) begin
        soap_wash_q  <= 1'b0;
        water_wash_q <= 1'b0;
      end else begin
        if (soap_set) begin
          soap_wash_q <= 1'b1;
        end
        if (water_set) begin
          water_wash_q <= 1'b1;
        end
      end
    end
  end

  // Moore actuator decode of the state register.
  always_comb begin
    bus.door_lock      = 1'b0;
    bus.motor_on       = 1'b0;
    bus.fill_value_on  = 1'b0;
    bus.drain_value_on = 1'b0;
    bus.done           = 1'b0;
    case (state)
      FILL: begin
        bus.door_lock     = 1'b1;
        bus.fill_value_on = 1'b1;
      end
      DETERGENT: begin
        bus.door_lock = 1'b1;
      end
      CYCLE: begin
        bus.door_lock = 1'b1;
        bus.motor_on  = 1'b1;
      end
      DRAIN: begin
        bus.door_lock      = 1'b1;
        bus.drain_value_on = 1'b1;
      end
      SPIN: begin
        bus.door_lock      = 1'b1;
        bus.motor_on       = 1'b1;
        bus.drain_value_on = 1'b1;
      end
      DONE: begin
        bus.done = 1'b1;
      end
      default: begin
        bus.door_lock = 1'b0;
      end
    endcase
  end

  // Registered flags and change pulse drive their outputs directly.
  always_comb begin
    bus.soap_wash  = soap_wash_q;
    bus.water_wash = water_wash_q;
    bus.change     = change_q;
  end

endmodule

// File: tb/tb_washing_machine.sv
// Scoreboard bench for washing_machine. The reference model walks a list of
// program phases built from the wash recipe; every clock the stimulus side
// pushes the expected outputs and a monitor compares them on the falling edge.
module tb_washing_machine;

  localparam int PH_FILL = 0;
  localparam int PH_DET  = 1;
  localparam int PH_CYC  = 2;
  localparam int PH_DRN  = 3;
  localparam int PH_SPIN = 4;
  localparam int PH_DONE = 5;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  washing_machine_if wif ();

  washing_machine dut (
    .clk   (clk),
    .reset (reset),
    .bus   (wif)
  );

  int         prog[$];
  int         idx;
  bit         rinse;
  logic [1:0] chg_m;
  logic [8:0] exp_q[$];
  int         total = 0;
  int         bad   = 0;

  // Expected outputs {lock,motor,fill,drain,done,soap,water,change[1:0]}.
  function automatic logic [8:0] model_out();
    logic [8:0] v;
    int k;
    v = '0;
    if (idx >= 0) begin
      k    = prog[idx];
      v[8] = (k != PH_DONE);
      v[7] = (k == PH_CYC) || (k == PH_SPIN);
      v[6] = (k == PH_FILL);
      v[5] = (k == PH_DRN) || (k == PH_SPIN);
      v[4] = (k == PH_DONE);
      v[3] = (idx >= 2);
      v[2] = rinse && (idx >= 4);
      v[1:0] = chg_m;
    end
    return v;
  endfunction

  function automatic logic [8:0] dut_out();
    return {wif.door_lock, wif.motor_on, wif.fill_value_on, wif.drain_value_on,
            wif.done, wif.soap_wash, wif.water_wash, wif.change};
  endfunction

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s at %0t: got lock,mot,fill,drn,done,soap,water,chg=%b required=%b",
               name, $time, got, expv);
    end
  endtask

  // One clock of stimulus: drive inputs, advance the model at the edge, push.
  task automatic drive(input logic [1:0] c, input logic dc, input logic st,
                       input logic f, input logic d, input logic ct,
                       input logic dr, input logic sp);
    bit adv;
    wif.coin            = c;
    wif.door_close      = dc;
    wif.start           = st;
    wif.filled          = f;
    wif.detergent_added = d;
    wif.cycle_timeout   = ct;
    wif.drained         = dr;
    wif.spin_timeout    = sp;
    @(posedge clk);
    if (!reset) begin
      idx   = -1;
      chg_m = '0;
    end else if (idx < 0) begin
      chg_m = '0;
      if (st && dc && (c >= 2'd2)) begin
        idx   = 0;
        chg_m = (c == 2'd3) ? 2'd1 : 2'd0;
      end
    end else begin
      chg_m = '0;
      case (prog[idx])
        PH_FILL: adv = f;
        PH_DET:  adv = d;
        PH_CYC:  adv = ct;
        PH_DRN:  adv = dr;
        PH_SPIN: adv = sp;
        default: adv = !dc;
      endcase
      if (adv) begin
        if (prog[idx] == PH_DONE) idx = -1;
        else idx = idx + 1;
      end
    end
    exp_q.push_back(model_out());
    #1;
  endtask

  task automatic idle_cyc(input logic [1:0] c, input logic dc, input logic st);
    drive(c, dc, st, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Raise one sensor (0..4 = filled, detergent, cycle, drained, spin) with door closed.
  task automatic sensor(input int which);
    drive(2'd0, 1'b1, 1'b0, which == 0, which == 1, which == 2, which == 3, which == 4);
  endtask

  // Monitor: compare one scoreboard entry per falling edge.
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("outputs", dut_out(), e);
      end
    end
  end

  initial begin
    logic dc;
    idx   = -1;
    chg_m = '0;
`ifdef RINSE_PASS_EN
    rinse = 1'b1;
    prog  = '{PH_FILL, PH_DET, PH_CYC, PH_DRN, PH_FILL, PH_CYC, PH_DRN, PH_SPIN, PH_DONE};
`else
    rinse = 1'b0;
    prog  = '{PH_FILL, PH_DET, PH_CYC, PH_DRN, PH_SPIN, PH_DONE};
`endif

    // Reset held low, then released with no payment.
    for (int i = 0; i < 3; i++) idle_cyc(2'd0, 1'b1, 1'b1);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) idle_cyc(2'd0, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) idle_cyc(2'd1, 1'b1, 1'b1);
    idle_cyc(2'd2, 1'b0, 1'b1);

    // Exact payment, sensors raised one at a time with quiet gaps.
    idle_cyc(2'd2, 1'b1, 1'b1);
    for (int s = 0; s < 5; s++) begin
      sensor(5);
      sensor(s);
      if (rinse && s == 3) begin
        sensor(0);
        sensor(2);
        sensor(5);
        sensor(3);
      end
    end
    idle_cyc(2'd0, 1'b1, 1'b0);
    idle_cyc(2'd0, 1'b0, 1'b0);
    idle_cyc(2'd0, 1'b0, 1'b0);

    // Overpayment, then every sensor held high: one phase per clock.
    idle_cyc(2'd3, 1'b1, 1'b1);
    for (int i = 0; i < 11; i++) drive(2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    idle_cyc(2'd0, 1'b0, 1'b0);
    idle_cyc(2'd0, 1'b0, 1'b0);

    // Reset asserted mid-CYCLE drops the actuators without a clock edge.
    idle_cyc(2'd2, 1'b1, 1'b1);
    sensor(0);
    sensor(1);
    sensor(5);
    reset = 1'b0;
    #1;
    check("async_reset", dut_out(), 9'b0);
    idx   = -1;
    chg_m = '0;
    if (exp_q.size() > 0) exp_q[exp_q.size() - 1] = '0;
    idle_cyc(2'd0, 1'b1, 1'b0);
    idle_cyc(2'd0, 1'b1, 1'b0);
    reset = 1'b1;
    idle_cyc(2'd0, 1'b1, 1'b0);

    // Randomized operation.
    for (int i = 0; i < 800; i++) begin
      if (idx < 0) dc = ($urandom_range(7) != 0);
      else dc = ($urandom_range(1) == 1);
      drive(2'($urandom_range(3)), dc, 1'($urandom_range(1)),
            $urandom_range(2) == 0, $urandom_range(2) == 0, $urandom_range(2) == 0,
            $urandom_range(2) == 0, $urandom_range(2) == 0);
    end

    @(negedge clk);
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d entries left required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
